// File: rtl/rf_write_arbiter.sv
// Two-source arbiter for the single register-file write port: A (load writeback) has
// fixed priority, B (ALU/PC) is force-granted after MAX_WAIT refused cycles.
module rf_write_arbiter #(
   parameter int unsigned MAX_WAIT = 4,
   parameter bit          DROP_R0  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold,
   input  logic        a_valid,
   input  logic [3:0]  a_reg,
   input  logic [15:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [3:0]  b_reg,
   input  logic [15:0] b_data,
   output logic        b_ready,
   output logic [3:0]  rf_dst_reg,
   output logic [15:0] rf_dst_data,
   output logic        rf_write_en,
   output logic [3:0]  b_wait_cnt
);

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   typedef enum logic {A_PRIO, B_FORCE} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt_nx;
   logic        grant_a, grant_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= A_PRIO;
         b_wait_cnt <= '0;
      end else begin
         state      <= state_nx;
         b_wait_cnt <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      cnt_nx   = b_wait_cnt;
      case (state)
         A_PRIO: begin
            if (!hold) begin
               if (a_valid)      grant_a = 1'b1;
               else if (b_valid) grant_b = 1'b1;
            end
         end
         B_FORCE: begin
            // A withdrawn B request releases the force state without a grant.
            if (!b_valid) state_nx = A_PRIO;
            else if (!hold) begin
               grant_b  = 1'b1;
               state_nx = A_PRIO;
            end
         end
         default: state_nx = A_PRIO;
      endcase

      if (!b_valid || grant_b)           cnt_nx = '0;
      else if (!hold && b_wait_cnt != MAX_W) cnt_nx = b_wait_cnt + 4'd1;

      if (state == A_PRIO && cnt_nx == MAX_W) state_nx = B_FORCE;
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   // Registered write stage; dst reg/data hold on idle cycles for forwarding visibility.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_write_en <= 1'b0;
         rf_dst_reg  <= '0;
         rf_dst_data <= '0;
      end else if (grant_a) begin
         rf_write_en <= !(DROP_R0 && a_reg == 4'd0);
         rf_dst_reg  <= a_reg;
         rf_dst_data <= a_data;
      end else if (grant_b) begin
         rf_write_en <= !(DROP_R0 && b_reg == 4'd0);
         rf_dst_reg  <= b_reg;
         rf_dst_data <= b_data;
      end else begin
         rf_write_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed cases plus random traffic, checked every cycle
// against a grant/starvation model and a 16-entry register file model.
module tb_rf_write_arbiter;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hold = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [3:0]  a_reg = '0, b_reg = '0;
   logic [15:0] a_data = '0, b_data = '0;
   logic        a_ready, b_ready, rf_write_en;
   logic [3:0]  rf_dst_reg, b_wait_cnt;
   logic [15:0] rf_dst_data;

   int ntests = 0;
   int nfail  = 0;

   rf_write_arbiter #(.MAX_WAIT(MAXW), .DROP_R0(1'b1)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
      .rf_dst_reg(rf_dst_reg), .rf_dst_data(rf_dst_data),
      .rf_write_en(rf_write_en), .b_wait_cnt(b_wait_cnt)
   );

   always #5 clk = ~clk;

   // Model: starvation count, last write, and register file contents.
   int          mcnt;
   logic        m_en;
   logic [3:0]  m_reg;
   logic [15:0] m_data;
   logic [15:0] rf_m [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // {a granted, b granted} from the arbitration rules.
   function automatic logic [1:0] mgrant();
      if (hold)          return 2'b00;
      if (mcnt == MAXW)  return {1'b0, b_valid};
      if (a_valid)       return 2'b10;
      if (b_valid)       return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mcnt   <= 0;
         m_en   <= 1'b0;
         m_reg  <= '0;
         m_data <= '0;
      end else begin
         logic [1:0] g;
         g = mgrant();
         if (m_en) rf_m[m_reg] <= m_data;
         if (g[1]) begin
            m_en <= (a_reg != 0); m_reg <= a_reg; m_data <= a_data;
         end else if (g[0]) begin
            m_en <= (b_reg != 0); m_reg <= b_reg; m_data <= b_data;
         end else begin
            m_en <= 1'b0;
         end
         if (!b_valid || g[0])          mcnt <= 0;
         else if (!hold && mcnt < MAXW) mcnt <= mcnt + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         logic [1:0] g;
         g = mgrant();
         chk("a_ready", a_ready, g[1]);
         chk("b_ready", b_ready, g[0]);
         chk("b_wait_cnt", b_wait_cnt, mcnt);
         chk("rf_write_en", rf_write_en, m_en);
         chk("rf_dst_reg", rf_dst_reg, m_reg);
         chk("rf_dst_data", rf_dst_data, m_data);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      a_valid = 0; b_valid = 0; hold = 0;
      cyc();
   endtask

   logic [15:0] r0_before;
   logic        ra, rb;

   initial begin
      for (int i = 0; i < 16; i++) rf_m[i] = '0;
      #1;
      chk("reset_en", rf_write_en, 0);
      chk("reset_reg", rf_dst_reg, 0);
      chk("reset_data", rf_dst_data, 0);
      chk("reset_cnt", b_wait_cnt, 0);
      chk("reset_ready", {a_ready, b_ready}, 0);
      cyc(); cyc();
      rst = 0;
      cyc();

      // Solo B
      b_valid = 1; b_reg = 3; b_data = 16'hBEEF; #1;
      chk("solo_b_ready", b_ready, 1);
      cyc(); b_valid = 0; #1;
      chk("solo_b_en", rf_write_en, 1);
      chk("solo_b_reg", rf_dst_reg, 3);
      chk("solo_b_data", rf_dst_data, 16'hBEEF);
      idle();

      // Starvation: B forced every fifth cycle
      a_valid = 1; a_reg = 1; a_data = 16'h00A1;
      b_valid = 1; b_reg = 2; b_data = 16'h00B2;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("starve_b_ready", b_ready, (i % 5) == 4);
         chk("starve_a_ready", a_ready, (i % 5) != 4);
         chk("starve_cnt", b_wait_cnt, i % 5);
         cyc();
      end
      idle();

      // Collision on R5
      a_valid = 1; a_reg = 5; a_data = 16'h1111;
      b_valid = 1; b_reg = 5; b_data = 16'h2222; #1;
      chk("coll_a_first", {a_ready, b_ready}, 2'b10);
      cyc(); a_valid = 0; #1;
      chk("coll_b_second", b_ready, 1);
      chk("coll_w1", rf_dst_data, 16'h1111);
      cyc(); b_valid = 0; #1;
      chk("coll_w2", rf_dst_data, 16'h2222);
      chk("coll_w2_reg", rf_dst_reg, 5);
      cyc();
      chk("coll_rf_r5", rf_m[5], 16'h2222);
      idle();

      // hold freezes grants and the counter
      a_valid = 1; a_reg = 1; a_data = 16'h0C01;
      b_valid = 1; b_reg = 2; b_data = 16'h0C02;
      cyc(); cyc();
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_ready", {a_ready, b_ready}, 2'b00);
         chk("hold_cnt", b_wait_cnt, 2);
         cyc();
         chk("hold_en", rf_write_en, 0);
      end
      hold = 0; #1;
      chk("hold_release_a", a_ready, 1);
      idle();

      // R0 write is handshaken but dropped
      r0_before = rf_m[0];
      a_valid = 1; a_reg = 0; a_data = 16'hDEAD; #1;
      chk("r0_ready", a_ready, 1);
      cyc(); a_valid = 0; #1;
      chk("r0_en", rf_write_en, 0);
      cyc();
      chk("r0_unchanged", rf_m[0], r0_before);
      idle();

      // Random traffic; requests stay stable until accepted or occasionally withdrawn
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         ra = a_ready; rb = b_ready;
         @(posedge clk); #1;
         if (!a_valid || ra || ($urandom % 16) == 0) begin
            a_valid = ($urandom % 2) == 1;
            a_reg   = 4'($urandom_range(0, 5));
            a_data  = 16'($urandom);
         end
         if (!b_valid || rb || ($urandom % 16) == 0) begin
            b_valid = ($urandom % 4) != 0;
            b_reg   = 4'($urandom_range(0, 5));
            b_data  = 16'($urandom);
         end
         hold = ($urandom % 6) == 0;
      end
      idle();

      // Reset mid-write
      a_valid = 1; a_reg = 7; a_data = 16'h1234;
      b_valid = 1; b_reg = 8; b_data = 16'h5678;
      cyc();
      chk("midrst_pre_en", rf_write_en, 1);
      #2 rst = 1; #1;
      chk("midrst_en", rf_write_en, 0);
      chk("midrst_cnt", b_wait_cnt, 0);
      cyc();
      rst = 0; #1;
      chk("post_rst_a", a_ready, 1);
      cyc();
      chk("post_rst_reg", rf_dst_reg, 7);
      idle();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
